// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_arbiter
//  Purpose  : Responder side of the shared-divider interface. Two client
//             blocks present a set of dividend lanes plus one common divisor;
//             a round-robin arbiter picks one request per enabled cycle,
//             registers its operands into a pipelined array divider, and
//             tracks it with a tag pipeline. When the tag reaches the tail,
//             the divider result is captured into the owning client's output
//             register and flagged valid for exactly one enabled cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1            single clock
//    rst            in   1            asynchronous active-high reset
//    en             in   1            global enable; all state holds when low
//    cN_req         in   1            client N request (held until granted)
//    cN_dividends   in   LANES*WIDTH  client N dividend lanes
//    cN_divisor     in   WIDTH        client N common divisor
//    cN_gnt         out  1            client N accepted this cycle (comb.)
//    cN_valid       out  1            client N result valid this cycle
//    cN_quotients   out  LANES*WIDTH  client N quotient lanes
//    cN_dbz         out  1            client N result came from zero divisor
//    div_en         out  1            divider enable (equals en)
//    div_dividends  out  LANES*WIDTH  registered dividends to the divider
//    div_divisor    out  WIDTH        registered divisor to the divider
//    div_quotients  in   LANES*WIDTH  divider results, DIV_LAT enabled cycles
//                                     after div_dividends/div_divisor
// ============================================================================
module div_share_arbiter #(
   parameter int WIDTH   = 27,
   parameter int LANES   = 6,
   parameter int DIV_LAT = 27
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   // client 0
   input  logic                     c0_req,
   input  logic [LANES*WIDTH-1:0]   c0_dividends,
   input  logic [WIDTH-1:0]         c0_divisor,
   output logic                     c0_gnt,
   output logic                     c0_valid,
   output logic [LANES*WIDTH-1:0]   c0_quotients,
   output logic                     c0_dbz,
   // client 1
   input  logic                     c1_req,
   input  logic [LANES*WIDTH-1:0]   c1_dividends,
   input  logic [WIDTH-1:0]         c1_divisor,
   output logic                     c1_gnt,
   output logic                     c1_valid,
   output logic [LANES*WIDTH-1:0]   c1_quotients,
   output logic                     c1_dbz,
   // divider
   output logic                     div_en,
   output logic [LANES*WIDTH-1:0]   div_dividends,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic [LANES*WIDTH-1:0]   div_quotients
);

   localparam int VEC_W     = LANES * WIDTH;
   // One extra stage because the operand register sits in front of the divider.
   localparam int TAG_DEPTH = DIV_LAT + 1;

   localparam logic [WIDTH-1:0] c_DIV_ONE = WIDTH'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                  ptr_q, ptr_d;               // 0: client 0 has priority
   logic [VEC_W-1:0]      div_dividends_q, div_dividends_d;
   logic [WIDTH-1:0]      div_divisor_q, div_divisor_d;

   logic [TAG_DEPTH-1:0]  tag_vld_q, tag_vld_d;
   logic [TAG_DEPTH-1:0]  tag_id_q,  tag_id_d;
   logic [TAG_DEPTH-1:0]  tag_dbz_q, tag_dbz_d;

   logic                  c0_vld_q, c0_vld_d;
   logic                  c1_vld_q, c1_vld_d;
   logic [VEC_W-1:0]      c0_quot_q, c0_quot_d;
   logic [VEC_W-1:0]      c1_quot_q, c1_quot_d;
   logic                  c0_dbz_q, c0_dbz_d;
   logic                  c1_dbz_q, c1_dbz_d;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_any_gnt;
   logic [VEC_W-1:0]      w_win_dividends;
   logic [WIDTH-1:0]      w_win_divisor;
   logic                  w_win_zero;

   // A lone requester always wins; under contention the pointer decides.
   assign w_gnt0    = en & c0_req & (~c1_req | ~ptr_q);
   assign w_gnt1    = en & c1_req & (~c0_req |  ptr_q);
   assign w_any_gnt = w_gnt0 | w_gnt1;

   assign w_win_dividends = w_gnt1 ? c1_dividends : c0_dividends;
   assign w_win_divisor   = w_gnt1 ? c1_divisor   : c0_divisor;
   assign w_win_zero      = (w_win_divisor == '0);

   // ------------------------------------------------------------------------
   // Tag pipeline push value and shift
   // ------------------------------------------------------------------------
   logic w_push_vld;
   logic w_push_id;
   logic w_push_dbz;

   assign w_push_vld = w_any_gnt;
   assign w_push_id  = w_gnt1;
   assign w_push_dbz = w_any_gnt & w_win_zero;

   generate
      if (TAG_DEPTH > 1) begin : g_tag_shift
         assign tag_vld_d = {tag_vld_q[TAG_DEPTH-2:0], w_push_vld};
         assign tag_id_d  = {tag_id_q[TAG_DEPTH-2:0],  w_push_id};
         assign tag_dbz_d = {tag_dbz_q[TAG_DEPTH-2:0], w_push_dbz};
      end else begin : g_tag_single
         assign tag_vld_d = w_push_vld;
         assign tag_id_d  = w_push_id;
         assign tag_dbz_d = w_push_dbz;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   logic             w_tail_vld;
   logic             w_tail_id;
   logic             w_tail_dbz;
   logic [VEC_W-1:0] w_tail_quot;

   assign w_tail_vld  = tag_vld_q[TAG_DEPTH-1];
   assign w_tail_id   = tag_id_q[TAG_DEPTH-1];
   assign w_tail_dbz  = tag_dbz_q[TAG_DEPTH-1];
   // The divider actually saw a divisor of 1, so its result is meaningless.
   assign w_tail_quot = w_tail_dbz ? '0 : div_quotients;

   always_comb begin
      // Pointer moves to whichever client was not served.
      ptr_d = w_any_gnt ? w_gnt0 : ptr_q;

      // Idle cycles feed a harmless 0/1 so the divider never sees a zero.
      div_dividends_d = w_any_gnt ? w_win_dividends : '0;
      div_divisor_d   = (w_any_gnt && !w_win_zero) ? w_win_divisor : c_DIV_ONE;

      c0_vld_d  = w_tail_vld & ~w_tail_id;
      c1_vld_d  = w_tail_vld &  w_tail_id;
      c0_quot_d = c0_vld_d ? w_tail_quot : c0_quot_q;
      c1_quot_d = c1_vld_d ? w_tail_quot : c1_quot_q;
      c0_dbz_d  = c0_vld_d ? w_tail_dbz  : c0_dbz_q;
      c1_dbz_d  = c1_vld_d ? w_tail_dbz  : c1_dbz_q;
   end

   // ------------------------------------------------------------------------
   // Registers: everything advances only on enabled cycles
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q           <= 1'b0;
         div_dividends_q <= '0;
         div_divisor_q   <= c_DIV_ONE;
         tag_vld_q       <= '0;
         tag_id_q        <= '0;
         tag_dbz_q       <= '0;
         c0_vld_q        <= 1'b0;
         c1_vld_q        <= 1'b0;
         c0_quot_q       <= '0;
         c1_quot_q       <= '0;
         c0_dbz_q        <= 1'b0;
         c1_dbz_q        <= 1'b0;
      end else if (en) begin
         ptr_q           <= ptr_d;
         div_dividends_q <= div_dividends_d;
         div_divisor_q   <= div_divisor_d;
         tag_vld_q       <= tag_vld_d;
         tag_id_q        <= tag_id_d;
         tag_dbz_q       <= tag_dbz_d;
         c0_vld_q        <= c0_vld_d;
         c1_vld_q        <= c1_vld_d;
         c0_quot_q       <= c0_quot_d;
         c1_quot_q       <= c1_quot_d;
         c0_dbz_q        <= c0_dbz_d;
         c1_dbz_q        <= c1_dbz_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign c0_gnt        = w_gnt0;
   assign c1_gnt        = w_gnt1;
   // Valid is held through stalls but only presented on an enabled cycle.
   assign c0_valid      = c0_vld_q & en;
   assign c1_valid      = c1_vld_q & en;
   assign c0_quotients  = c0_quot_q;
   assign c1_quotients  = c1_quot_q;
   assign c0_dbz        = c0_dbz_q;
   assign c1_dbz        = c1_dbz_q;
   assign div_en        = en;
   assign div_dividends = div_dividends_q;
   assign div_divisor   = div_divisor_q;

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_share_arbiter
//  Purpose  : Self-checking bench for div_share_arbiter. Provides a pipelined
//             array-divider model and a transaction-level reference model
//             (round-robin pointer, result queue keyed by enabled-cycle count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_arbiter;

   localparam int W   = 27;
   localparam int L   = 6;
   localparam int LAT = 27;
   localparam int VW  = W * L;

   typedef logic [VW-1:0] vec_t;
   typedef logic [W-1:0]  word_t;
   typedef struct { int cli; int due; vec_t quo; bit dbz; } res_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  en  = 1'b0;
   logic  c0_req = 1'b0, c1_req = 1'b0;
   vec_t  c0_dividends = '0, c1_dividends = '0;
   word_t c0_divisor = '0, c1_divisor = '0;
   logic  c0_gnt, c1_gnt, c0_valid, c1_valid, c0_dbz, c1_dbz, div_en;
   vec_t  c0_quotients, c1_quotients, div_dividends, div_quotients;
   word_t div_divisor;

   div_share_arbiter #(.WIDTH(W), .LANES(L), .DIV_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .en(en),
      .c0_req(c0_req), .c0_dividends(c0_dividends), .c0_divisor(c0_divisor),
      .c0_gnt(c0_gnt), .c0_valid(c0_valid), .c0_quotients(c0_quotients), .c0_dbz(c0_dbz),
      .c1_req(c1_req), .c1_dividends(c1_dividends), .c1_divisor(c1_divisor),
      .c1_gnt(c1_gnt), .c1_valid(c1_valid), .c1_quotients(c1_quotients), .c1_dbz(c1_dbz),
      .div_en(div_en), .div_dividends(div_dividends), .div_divisor(div_divisor),
      .div_quotients(div_quotients)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Lane-wise unsigned division; zero divisor yields zero lanes
   // ------------------------------------------------------------------------
   function automatic vec_t ref_quot(input vec_t d, input word_t v);
      vec_t r = '0;
      if (v != '0)
         for (int i = 0; i < L; i++) r[i*W +: W] = d[i*W +: W] / v;
      return r;
   endfunction

   function automatic vec_t fill(input word_t x);
      vec_t r;
      for (int i = 0; i < L; i++) r[i*W +: W] = x;
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r;
      for (int i = 0; i < L; i++) r[i*W +: W] = word_t'($urandom);
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Attached divider: LAT enabled-cycle pipeline
   // ------------------------------------------------------------------------
   vec_t dpipe [LAT];
   always_ff @(posedge clk) begin
      if (div_en) begin
         dpipe[0] <= ref_quot(div_dividends, div_divisor);
         for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      end
   end
   assign div_quotients = dpipe[LAT-1];

   // ------------------------------------------------------------------------
   // Staged stimulus and reference model
   // ------------------------------------------------------------------------
   bit    s_en = 1'b1, s_r0 = 1'b0, s_r1 = 1'b0;
   vec_t  s_d0 = '0, s_d1 = '0;
   word_t s_v0 = '0, s_v1 = '0;

   bit    m_ptr = 1'b0;
   int    m_ecnt = 0;
   res_t  mq [$];
   bit    xg0, xg1, xv0, xv1, xd0, xd1;
   vec_t  xq0 = '0, xq1 = '0;

   int    checks = 0;
   int    errs   = 0;
   int    cycn   = 0;

   // One clock: apply staged inputs, then predict this cycle's outputs.
   task automatic cyc();
      res_t r;
      @(posedge clk); #1;
      rst = 1'b0; en = s_en;
      c0_req = s_r0; c0_dividends = s_d0; c0_divisor = s_v0;
      c1_req = s_r1; c1_dividends = s_d1; c1_divisor = s_v1;
      @(negedge clk);
      cycn++;
      xg0 = s_en && s_r0 && (!s_r1 || !m_ptr);
      xg1 = s_en && s_r1 && (!s_r0 ||  m_ptr);
      xv0 = 1'b0; xv1 = 1'b0;
      if (s_en && mq.size() > 0 && mq[0].due == m_ecnt) begin
         if (mq[0].cli == 0) begin xv0 = 1'b1; xq0 = mq[0].quo; xd0 = mq[0].dbz; end
         else                begin xv1 = 1'b1; xq1 = mq[0].quo; xd1 = mq[0].dbz; end
         mq.delete(0);
      end
      if (s_en) begin
         if (xg0 || xg1) begin
            r.cli = xg1 ? 1 : 0;
            r.due = m_ecnt + LAT + 2;
            r.quo = xg1 ? ref_quot(s_d1, s_v1) : ref_quot(s_d0, s_v0);
            r.dbz = xg1 ? (s_v1 == '0) : (s_v0 == '0);
            mq.push_back(r);
            m_ptr = xg0;
         end
         m_ecnt++;
      end
   endtask

   // Assert reset mid-cycle and leave it high; the next cyc() releases it.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b1; c0_req = 1'b0; c1_req = 1'b0;
      s_en = 1'b1; s_r0 = 1'b0; s_r1 = 1'b0;
      mq.delete(); m_ptr = 1'b0;
      xq0 = '0; xq1 = '0; xd0 = 1'b0; xd1 = 1'b0;
      xv0 = 1'b0; xv1 = 1'b0; xg0 = 1'b0; xg1 = 1'b0;
      repeat (2) @(negedge clk);
      cycn = -1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      checks++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b%b want 00", c0_valid, c1_valid); end
      checks++; if (c0_quotients !== '0 || c1_quotients !== '0) begin errs++; $display("FAIL reset_quot: got %h / %h want 0", c0_quotients, c1_quotients); end
      checks++; if (c0_dbz !== 1'b0 || c1_dbz !== 1'b0) begin errs++; $display("FAIL reset_dbz: got %b%b want 00", c0_dbz, c1_dbz); end
      checks++; if (div_dividends !== '0) begin errs++; $display("FAIL reset_div_dividends: got %h want 0", div_dividends); end
      checks++; if (div_divisor !== word_t'(1)) begin errs++; $display("FAIL reset_div_divisor: got %0d want 1", div_divisor); end
      checks++; if (div_en !== en) begin errs++; $display("FAIL reset_div_en: got %b want %b", div_en, en); end
   endtask

   task automatic test_single();
      int vcnt = 0, vcyc = -1;
      vec_t got = '0;
      do_reset();
      for (int k = 0; k <= 40; k++) begin
         if (k == 5) begin s_r0 = 1'b1; s_d0 = fill(word_t'(100)); s_v0 = word_t'(4); end
         cyc();
         if (xg0) s_r0 = 1'b0;
         checks++; if (c0_gnt !== xg0) begin errs++; $display("FAIL single c0_gnt @%0d: got %b want %b", cycn, c0_gnt, xg0); end
         checks++; if (c1_gnt !== xg1) begin errs++; $display("FAIL single c1_gnt @%0d: got %b want %b", cycn, c1_gnt, xg1); end
         checks++; if (c0_valid !== xv0) begin errs++; $display("FAIL single c0_valid @%0d: got %b want %b", cycn, c0_valid, xv0); end
         checks++; if (c1_valid !== xv1) begin errs++; $display("FAIL single c1_valid @%0d: got %b want %b", cycn, c1_valid, xv1); end
         if (k == 6) begin
            checks++; if (div_divisor !== word_t'(4) || div_dividends !== fill(word_t'(100))) begin errs++; $display("FAIL single div_operands: got %h/%0d want all 100 / 4", div_dividends, div_divisor); end
         end
         if (c0_valid === 1'b1) begin vcnt++; vcyc = cycn; got = c0_quotients; end
      end
      checks++; if (vcnt != 1 || vcyc != 34) begin errs++; $display("FAIL single latency: got %0d valids at cycle %0d want 1 at 34", vcnt, vcyc); end
      checks++; if (got !== fill(word_t'(25)) || c0_dbz !== 1'b0) begin errs++; $display("FAIL single result: got q=%h dbz=%b want all 25 dbz=0", got, c0_dbz); end
   endtask

   task automatic test_contention();
      int g0 [$]; int g1 [$];
      do_reset();
      s_r0 = 1'b1; s_r1 = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (k == 20) begin s_r0 = 1'b0; s_r1 = 1'b0; end
         s_d0 = rand_vec(); s_v0 = word_t'($urandom_range(1, 999));
         s_d1 = rand_vec(); s_v1 = word_t'($urandom_range(1, 999));
         cyc();
         if (k < 20) begin
            checks++; if (c0_gnt !== (k % 2 == 0) || c1_gnt !== (k % 2 == 1)) begin errs++; $display("FAIL contention alternate @%0d: got %b%b", cycn, c0_gnt, c1_gnt); end
            if (k % 2 == 0) g0.push_back(cycn); else g1.push_back(cycn);
         end
         checks++; if (c0_valid !== xv0) begin errs++; $display("FAIL contention c0_valid @%0d: got %b want %b", cycn, c0_valid, xv0); end
         checks++; if (c1_valid !== xv1) begin errs++; $display("FAIL contention c1_valid @%0d: got %b want %b", cycn, c1_valid, xv1); end
         if (xv0) begin checks++; if (c0_quotients !== xq0 || c0_dbz !== xd0) begin errs++; $display("FAIL contention c0_result @%0d: got %h want %h", cycn, c0_quotients, xq0); end end
         if (xv1) begin checks++; if (c1_quotients !== xq1 || c1_dbz !== xd1) begin errs++; $display("FAIL contention c1_result @%0d: got %h want %h", cycn, c1_quotients, xq1); end end
         if (c0_valid === 1'b1) begin
            checks++; if (g0.size() == 0 || cycn - g0[0] != LAT + 2) begin errs++; $display("FAIL contention c0_latency @%0d: got %0d want %0d", cycn, (g0.size() == 0) ? -1 : cycn - g0[0], LAT + 2); end
            if (g0.size() > 0) g0.delete(0);
         end
         if (c1_valid === 1'b1) begin
            checks++; if (g1.size() == 0 || cycn - g1[0] != LAT + 2) begin errs++; $display("FAIL contention c1_latency @%0d: got %0d want %0d", cycn, (g1.size() == 0) ? -1 : cycn - g1[0], LAT + 2); end
            if (g1.size() > 0) g1.delete(0);
         end
      end
      checks++; if (g0.size() != 0 || g1.size() != 0) begin errs++; $display("FAIL contention missing: got %0d/%0d outstanding want 0/0", g0.size(), g1.size()); end
   endtask

   task automatic test_dbz();
      int vcnt = 0;
      do_reset();
      for (int k = 0; k < 36; k++) begin
         if (k == 2) begin s_r1 = 1'b1; s_d1 = fill(word_t'(7)); s_v1 = '0; end
         cyc();
         if (xg1) s_r1 = 1'b0;
         checks++; if (c1_gnt !== xg1) begin errs++; $display("FAIL dbz c1_gnt @%0d: got %b want %b", cycn, c1_gnt, xg1); end
         checks++; if (c1_valid !== xv1) begin errs++; $display("FAIL dbz c1_valid @%0d: got %b want %b", cycn, c1_valid, xv1); end
         if (k == 3) begin
            checks++; if (div_divisor !== word_t'(1) || div_dividends !== fill(word_t'(7))) begin errs++; $display("FAIL dbz div_operands: got %h/%0d want all 7 / 1", div_dividends, div_divisor); end
         end
         if (c1_valid === 1'b1) begin
            vcnt++;
            checks++; if (c1_quotients !== '0 || c1_dbz !== 1'b1) begin errs++; $display("FAIL dbz result: got q=%h dbz=%b want 0 dbz=1", c1_quotients, c1_dbz); end
         end
      end
      checks++; if (vcnt != 1) begin errs++; $display("FAIL dbz count: got %0d want 1", vcnt); end
   endtask

   task automatic test_stall();
      int vcyc = -1;
      vec_t got = '0;
      do_reset();
      for (int k = 0; k < 62; k++) begin
         if (k == 5)  begin s_r0 = 1'b1; s_d0 = fill(word_t'(100)); s_v0 = word_t'(4); end
         if (k == 15) begin s_r1 = 1'b1; s_d1 = rand_vec(); s_v1 = word_t'($urandom_range(1, 77)); end
         s_en = !(k >= 15 && k <= 24);
         cyc();
         if (xg0) s_r0 = 1'b0;
         if (xg1) s_r1 = 1'b0;
         if (k >= 15 && k <= 24) begin
            checks++; if ({c0_gnt, c1_gnt, c0_valid, c1_valid} !== 4'b0) begin errs++; $display("FAIL stall quiet @%0d: got gnt=%b%b valid=%b%b want 0", cycn, c0_gnt, c1_gnt, c0_valid, c1_valid); end
         end
         checks++; if (c1_gnt !== xg1) begin errs++; $display("FAIL stall c1_gnt @%0d: got %b want %b", cycn, c1_gnt, xg1); end
         checks++; if (c0_valid !== xv0 || c1_valid !== xv1) begin errs++; $display("FAIL stall valid @%0d: got %b%b want %b%b", cycn, c0_valid, c1_valid, xv0, xv1); end
         if (xv1) begin checks++; if (c1_quotients !== xq1 || c1_dbz !== xd1) begin errs++; $display("FAIL stall c1_result @%0d: got %h want %h", cycn, c1_quotients, xq1); end end
         if (c0_valid === 1'b1) begin vcyc = cycn; got = c0_quotients; end
      end
      s_en = 1'b1;
      checks++; if (vcyc != 44 || got !== fill(word_t'(25))) begin errs++; $display("FAIL stall c0_result: got cycle %0d q=%h want cycle 44 all 25", vcyc, got); end
   endtask

   task automatic test_reset_midflight();
      int vcnt = 0;
      do_reset();
      for (int k = 0; k < 46; k++) begin
         if (k == 0)  begin s_r1 = 1'b1; s_d1 = rand_vec(); s_v1 = word_t'($urandom_range(1, 50)); end
         if (k == 31) begin s_r0 = 1'b1; s_d0 = rand_vec(); s_v0 = word_t'($urandom_range(1, 50)); end
         cyc();
         if (xg0) s_r0 = 1'b0;
         if (xg1) s_r1 = 1'b0;
         checks++; if (c0_valid !== xv0 || c1_valid !== xv1) begin errs++; $display("FAIL rstmid valid @%0d: got %b%b want %b%b", cycn, c0_valid, c1_valid, xv0, xv1); end
         if (xv1) begin checks++; if (c1_quotients !== xq1) begin errs++; $display("FAIL rstmid c1_result @%0d: got %h want %h", cycn, c1_quotients, xq1); end end
      end
      do_reset();
      checks++; if (c1_quotients !== '0 || c1_dbz !== 1'b0 || c0_valid !== 1'b0 || c1_valid !== 1'b0) begin errs++; $display("FAIL rstmid reset_outputs: got q1=%h dbz1=%b valid=%b%b want 0", c1_quotients, c1_dbz, c0_valid, c1_valid); end
      checks++; if (div_divisor !== word_t'(1) || div_dividends !== '0) begin errs++; $display("FAIL rstmid reset_div: got %h/%0d want 0/1", div_dividends, div_divisor); end
      for (int k = 0; k < 80; k++) begin
         if (k == 40) begin s_r0 = 1'b1; s_d0 = rand_vec(); s_v0 = word_t'($urandom_range(1, 300)); end
         cyc();
         if (xg0) s_r0 = 1'b0;
         if (k < 40) begin
            checks++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) begin errs++; $display("FAIL rstmid ghost_valid @%0d: got %b%b want 00", cycn, c0_valid, c1_valid); end
         end
         checks++; if (c0_gnt !== xg0) begin errs++; $display("FAIL rstmid c0_gnt @%0d: got %b want %b", cycn, c0_gnt, xg0); end
         if (c0_valid === 1'b1) begin
            vcnt++;
            checks++; if (!xv0 || c0_quotients !== xq0) begin errs++; $display("FAIL rstmid new_result @%0d: got %h want %h", cycn, c0_quotients, xq0); end
         end
      end
      checks++; if (vcnt != 1) begin errs++; $display("FAIL rstmid new_count: got %0d want 1", vcnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 440; k++) begin
         s_en = (k >= 400) || ($urandom_range(0, 9) != 0);
         if (k < 400 && !s_r0 && $urandom_range(0, 2) != 0) begin
            s_r0 = 1'b1; s_d0 = rand_vec();
            s_v0 = ($urandom_range(0, 5) == 0) ? '0 : word_t'($urandom_range(1, 5000));
         end
         if (k < 400 && !s_r1 && $urandom_range(0, 2) != 0) begin
            s_r1 = 1'b1; s_d1 = rand_vec();
            s_v1 = ($urandom_range(0, 5) == 0) ? '0 : word_t'($urandom_range(1, 5000));
         end
         cyc();
         if (xg0) s_r0 = 1'b0;
         if (xg1) s_r1 = 1'b0;
         checks++; if (c0_gnt !== xg0 || c1_gnt !== xg1) begin errs++; $display("FAIL random gnt @%0d: got %b%b want %b%b", cycn, c0_gnt, c1_gnt, xg0, xg1); end
         checks++; if (c0_valid !== xv0 || c1_valid !== xv1) begin errs++; $display("FAIL random valid @%0d: got %b%b want %b%b", cycn, c0_valid, c1_valid, xv0, xv1); end
         if (xv0) begin checks++; if (c0_quotients !== xq0 || c0_dbz !== xd0) begin errs++; $display("FAIL random c0_result @%0d: got %h/%b want %h/%b", cycn, c0_quotients, c0_dbz, xq0, xd0); end end
         if (xv1) begin checks++; if (c1_quotients !== xq1 || c1_dbz !== xd1) begin errs++; $display("FAIL random c1_result @%0d: got %h/%b want %h/%b", cycn, c1_quotients, c1_dbz, xq1, xd1); end end
      end
      checks++; if (mq.size() != 0) begin errs++; $display("FAIL random drain: got %0d outstanding want 0", mq.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_dbz();
      test_stall();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Responder side of the shared-divider interface: serves two client blocks (e.g. cholesky, back-substitution) through one pipelined array divider.

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, 27, operand and quotient lane width in bits.
REQ-002 The block SHALL have parameter LANES, 6, number of dividend/quotient lanes per request.
REQ-003 The block SHALL have parameter DIV_LAT, 27, enabled-cycle latency of the attached divider from div_* inputs to div_quotients.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 en  in  1  global enable; when low all state holds.
REQ-007 cN_req  in  1  client N (N=0,1) request, held until granted.
REQ-008 cN_dividends  in  LANES*WIDTH  client N dividend lanes.
REQ-009 cN_divisor  in  WIDTH  client N common divisor.
REQ-010 cN_gnt  out  1  client N request accepted this cycle.
REQ-011 cN_valid  out  1  client N result valid this cycle.
REQ-012 cN_quotients  out  LANES*WIDTH  client N quotient lanes.
REQ-013 cN_dbz  out  1  client N result came from a zero divisor; qualified by cN_valid.
REQ-014 div_en  out  1  divider enable, equal to en.
REQ-015 div_dividends  out  LANES*WIDTH  registered dividends to divider.
REQ-016 div_divisor  out  WIDTH  registered divisor to divider.
REQ-017 div_quotients  in  LANES*WIDTH  divider results.

Function
REQ-018 Arbitration SHALL be round-robin with a 1-bit priority pointer; the pointer SHALL move to the non-granted client after every grant.
REQ-019 cN_gnt SHALL be combinational and SHALL assert only when en=1, cN_req=1, and client N wins; at most one gnt SHALL be high per cycle.
REQ-020 If only one client requests, it SHALL be granted regardless of the pointer.
REQ-021 On the edge ending a grant cycle, the block SHALL register the winner's operands into div_dividends/div_divisor and push {valid=1, id, dbz} into a tag pipeline of depth DIV_LAT+1.
REQ-022 On an enabled cycle with no grant, the block SHALL load div_dividends=0 and div_divisor=1 and push valid=0.
REQ-023 A zero client divisor SHALL be replaced by 1 at the divider input, with dbz=1 recorded in the tag.
REQ-024 At the tag-pipeline tail, the block SHALL register div_quotients into the id's output register and set that client's valid register; quotients SHALL be forced to 0 when dbz=1.
REQ-025 cN_valid SHALL equal its valid register AND en, high for exactly one enabled cycle per granted request.
REQ-026 With en continuously high, cN_valid SHALL assert exactly DIV_LAT+2 cycles after the cN_gnt cycle.
REQ-027 cN_quotients and cN_dbz SHALL hold their last values until the next result for client N.
REQ-028 When en=0, the tag pipeline, output registers, pointer and operand registers SHALL hold and all gnt SHALL be 0; latency SHALL count enabled cycles only.
REQ-029 Back-to-back grants SHALL be sustained at one per enabled cycle with no loss or reordering of results.
REQ-030 Requests and results in the same cycle SHALL be independent; a client may be granted while receiving an earlier result.

Reset
REQ-031 While rst=1, all state SHALL reset asynchronously: tag pipeline valid bits, cN_valid, cN_dbz, cN_quotients, and div_dividends SHALL be 0; div_divisor SHALL be 1; pointer SHALL select client 0.
REQ-032 Requests in flight at reset SHALL be discarded and SHALL produce no cN_valid.
REQ-033 After rst deasserts, the first grant SHALL occur on the first cycle with en=1 and a request pending.

Verification
REQ-034 Single request: c0_req with dividends all 100 and divisor 4, gnt at cycle 5 -> c0_valid only at cycle 34 (DIV_LAT=27), all lanes 25, c0_dbz=0.
REQ-035 Contention: c0_req and c1_req both held from cycle 0 after reset -> grants alternate c0,c1,c0,c1 and each client's valid appears 29 cycles after each of its grants, in order.
REQ-036 Divide by zero: c1 divisor 0, dividends 7 -> div_divisor=1 on the following cycle, c1_valid with quotients 0 and c1_dbz=1.
REQ-037 Stall: en low for 10 cycles mid-flight -> no gnt or valid during the stall, and the result arrives 10 cycles later than in REQ-034 with a correct value.
REQ-038 Reset mid-flight: rst pulse 15 cycles after a grant -> no cN_valid ever for that request, outputs at reset values, and a new request completes normally.
